stage_mem: RTL and testbench

//  Memory-access pipeline stage; sits directly downstream of the execute stage and feeds write-back.

---
 rtl/stage_mem_pkg.sv | 13 +
 rtl/stage_mem_bus.sv | 64 ++++++
 rtl/stage_mem.sv | 103 ++++++++++
 tb/tb_stage_mem.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// rtl/stage_mem_pkg.sv - shared writeback-source codes and memory-stage state encoding
package stage_mem_pkg;

    localparam int RF_SRC_WIDTH = 2;
    localparam logic [RF_SRC_WIDTH-1:0] RF_SRC_ALU = 2'd0;
    localparam logic [RF_SRC_WIDTH-1:0] RF_SRC_MEM = 2'd1;

    typedef enum logic {
        MEM_ST_IDLE   = 1'b0,
        MEM_ST_ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/stage_mem_bus.sv
// rtl/stage_mem_bus.sv - mem_bus_ctrl: IDLE/ACCESS bus FSM with ack timeout
module mem_bus_ctrl
    import stage_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic busy,
    output logic done,
    output logic timeout
);

    mem_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             last_cycle;

    assign last_cycle = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign busy       = (state == MEM_ST_ACCESS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MEM_ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state)
            MEM_ST_IDLE: begin
                if (start) state_next = MEM_ST_ACCESS;
            end
            MEM_ST_ACCESS: begin
                if (ack) begin
                    done       = 1'b1;
                    state_next = MEM_ST_IDLE;
                end else if (last_cycle) begin
                    timeout    = 1'b1;
                    state_next = MEM_ST_IDLE;
                end
            end
            default: state_next = MEM_ST_IDLE;
        endcase
    end

    // Counter only advances while waiting; any exit from ACCESS rearms it at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (busy && !ack && !last_cycle) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - memory-access pipeline stage; optional MEM_ALIGN_CHECK_EN
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             ex_pc,
    input  logic [31:0]             ex_inst,
    input  logic [31:0]             ex_opResult,
    input  logic                    ex_memWE,
    input  logic [31:0]             ex_memData,
    input  logic                    ex_rfWE,
    input  logic [4:0]              ex_rfDst,
    input  logic [RF_SRC_WIDTH-1:0] ex_rfSrc,
    output logic [31:0]             mem_pc,
    output logic [31:0]             mem_inst,
    output logic [31:0]             mem_aluResult,
    output logic [31:0]             mem_loadData,
    output logic                    mem_rfWE,
    output logic [4:0]              mem_rfDst,
    output logic [RF_SRC_WIDTH-1:0] mem_rfSrc,
    output logic                    mem_busErr,
    output logic                    mem_alignErr,
    output logic                    stall_req,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [31:0]             dmem_addr,
    output logic [31:0]             dmem_wdata,
    input  logic [31:0]             dmem_rdata,
    input  logic                    dmem_ack
);

    logic        capture, mem_op, misaligned, start;
    logic        busy, done, timeout;
    logic        we_reg, rf_we_reg;
    logic [31:0] wdata_reg;

    assign capture = !stall_req;
    assign mem_op  = ex_memWE | (ex_rfSrc == RF_SRC_MEM);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op && (ex_opResult[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign start = capture && mem_op && !misaligned;

    mem_bus_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_bus (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ack    (dmem_ack),
        .busy   (busy),
        .done   (done),
        .timeout(timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_pc        <= '0;
            mem_inst      <= '0;
            mem_aluResult <= '0;
            mem_rfDst     <= '0;
            mem_rfSrc     <= '0;
            we_reg        <= 1'b0;
            rf_we_reg     <= 1'b0;
            wdata_reg     <= '0;
            mem_loadData  <= '0;
            mem_busErr    <= 1'b0;
            mem_alignErr  <= 1'b0;
        end else if (capture) begin
            mem_pc        <= ex_pc;
            mem_inst      <= ex_inst;
            mem_aluResult <= ex_opResult;
            mem_rfDst     <= ex_rfDst;
            mem_rfSrc     <= ex_rfSrc;
            we_reg        <= ex_memWE;
            rf_we_reg     <= ex_rfWE;
            wdata_reg     <= ex_memData;
            mem_loadData  <= '0;
            mem_busErr    <= 1'b0;
            mem_alignErr  <= misaligned;
        end else begin
            if (done && !we_reg) mem_loadData <= dmem_rdata;
            if (timeout) mem_busErr <= 1'b1;
        end
    end

    assign stall_req  = busy;
    assign dmem_req   = busy;
    assign dmem_we    = busy & we_reg;
    assign dmem_addr  = {mem_aluResult[31:2], 2'b00};
    assign dmem_wdata = wdata_reg;
    assign mem_rfWE   = rf_we_reg & !busy & !mem_busErr & !mem_alignErr;

endmodule

// File: tb/tb_stage_mem.sv
// tb/tb_stage_mem.sv - directed self-checking bench for stage_mem
module tb_stage_mem;
    import stage_mem_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [31:0]             ex_pc, ex_inst, ex_opResult, ex_memData;
    logic                    ex_memWE, ex_rfWE;
    logic [4:0]              ex_rfDst;
    logic [RF_SRC_WIDTH-1:0] ex_rfSrc;
    logic [31:0]             mem_pc, mem_inst, mem_aluResult, mem_loadData;
    logic                    mem_rfWE, mem_busErr, mem_alignErr;
    logic [4:0]              mem_rfDst;
    logic [RF_SRC_WIDTH-1:0] mem_rfSrc;
    logic                    stall_req, dmem_req, dmem_we, dmem_ack;
    logic [31:0]             dmem_addr, dmem_wdata, dmem_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    stage_mem #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_opResult(ex_opResult),
        .ex_memWE(ex_memWE), .ex_memData(ex_memData), .ex_rfWE(ex_rfWE),
        .ex_rfDst(ex_rfDst), .ex_rfSrc(ex_rfSrc),
        .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_aluResult(mem_aluResult),
        .mem_loadData(mem_loadData), .mem_rfWE(mem_rfWE), .mem_rfDst(mem_rfDst),
        .mem_rfSrc(mem_rfSrc), .mem_busErr(mem_busErr), .mem_alignErr(mem_alignErr),
        .stall_req(stall_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] addr, input logic we, input logic [31:0] data,
                         input logic rfwe, input logic [RF_SRC_WIDTH-1:0] src);
        ex_pc       = 32'h1000 + addr;
        ex_inst     = 32'h0000_0013;
        ex_opResult = addr;
        ex_memWE    = we;
        ex_memData  = data;
        ex_rfWE     = rfwe;
        ex_rfDst    = 5'd5;
        ex_rfSrc    = src;
    endtask

    task automatic nop();
        drive(32'h0, 1'b0, 32'h0, 1'b0, RF_SRC_ALU);
    endtask

    initial begin
        int n;
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        nop();
        @(negedge clk); cycle();
        rst = 1'b0;
        check("rst_alu", mem_aluResult, 0);
        check("rst_rfwe", mem_rfWE, 0);
        check("rst_req", dmem_req, 0);
        check("rst_stall", stall_req, 0);
        check("rst_loaddata", mem_loadData, 0);

        // ALU op
        drive(32'h1234, 1'b0, 32'h0, 1'b1, RF_SRC_ALU);
        cycle();
        nop();
        check("alu_result", mem_aluResult, 32'h1234);
        check("alu_rfwe", mem_rfWE, 1);
        check("alu_req", dmem_req, 0);
        check("alu_stall", stall_req, 0);
        cycle();
        check("alu_rfwe_once", mem_rfWE, 0);

        // Load acked in the third ACCESS cycle
        drive(32'h40, 1'b0, 32'h0, 1'b1, RF_SRC_MEM);
        cycle();
        nop();
        for (int k = 1; k <= 3; k++) begin
            check("ld_stall", stall_req, 1);
            check("ld_rfwe_stalled", mem_rfWE, 0);
            if (k == 3) begin
                dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
            end
            cycle();
        end
        dmem_ack = 1'b0; dmem_rdata = '0;
        check("ld_stall_drop", stall_req, 0);
        check("ld_data", mem_loadData, 32'hDEADBEEF);
        check("ld_rfwe", mem_rfWE, 1);
        cycle();
        check("ld_rfwe_once", mem_rfWE, 0);

        // Store with immediate ack
        drive(32'h80, 1'b1, 32'hA5A5A5A5, 1'b0, RF_SRC_ALU);
        cycle();
        nop();
        check("st_req", dmem_req, 1);
        check("st_we", dmem_we, 1);
        check("st_addr", dmem_addr, 32'h80);
        check("st_wdata", dmem_wdata, 32'hA5A5A5A5);
        dmem_ack = 1'b1;
        cycle();
        dmem_ack = 1'b0;
        check("st_stall", stall_req, 0);
        check("st_rfwe", mem_rfWE, 0);

        // Load never acked -> timeout
        drive(32'h44, 1'b0, 32'h0, 1'b1, RF_SRC_MEM);
        cycle();
        nop();
        n = 0;
        while (dmem_req && n < 40) begin
            n++;
            cycle();
        end
        check("to_req_cycles", n, 16);
        check("to_buserr", mem_busErr, 1);
        check("to_rfwe", mem_rfWE, 0);
        check("to_stall", stall_req, 0);
        check("to_loaddata", mem_loadData, 0);
        cycle();
        check("to_buserr_clear", mem_busErr, 0);

        // Reset during the second ACCESS cycle
        drive(32'h100, 1'b0, 32'h0, 1'b1, RF_SRC_MEM);
        cycle();
        nop();
        cycle();
        check("rsta_req_before", dmem_req, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rsta_req", dmem_req, 0);
        check("rsta_stall", stall_req, 0);
        check("rsta_alu", mem_aluResult, 0);
        check("rsta_rfwe", mem_rfWE, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        cycle();
        dmem_ack = 1'b0; dmem_rdata = '0;
        check("stray_req", dmem_req, 0);
        check("stray_loaddata", mem_loadData, 0);
        check("stray_stall", stall_req, 0);

        // Misaligned load
        drive(32'h41, 1'b0, 32'h0, 1'b1, RF_SRC_MEM);
        cycle();
        nop();
`ifdef MEM_ALIGN_CHECK_EN
        check("al_err", mem_alignErr, 1);
        check("al_req", dmem_req, 0);
        check("al_stall", stall_req, 0);
        check("al_rfwe", mem_rfWE, 0);
`else
        check("al_err", mem_alignErr, 0);
        check("al_req", dmem_req, 1);
        check("al_addr", dmem_addr, 32'h40);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        cycle();
        dmem_ack = 1'b0;
        check("al_data", mem_loadData, 32'hCAFEF00D);
        check("al_rfwe", mem_rfWE, 1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
